dmem_lsu: RTL and testbench
===========================

Name: dmem_lsu

Overview:
- Parametrised successor to the core's byte-addressed data memory. It combines a load/store formatting unit with an internal byte-enable synchronous RAM.
- Accepts one load or store request at a time over a valid/ready handshake. Formats sub-word data, flags misaligned or illegal accesses, and returns a response over a second valid/ready handshake.
- Sits in the MEM stage; the pipeline stalls on req_ready/rsp_valid.
- Supports DATA_W 32 (RV32) or 64 (RV64, which adds LD/LWU/SD).

Parameters:
- ADDR_W, 9, byte-address width; memory is 2**ADDR_W bytes.
- DATA_W, 32, data width in bits; legal values are 32 or 64; any other value is an elaboration error.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3 (width/sign)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data, LSB-aligned
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  DATA_W  formatted load data; 0 for stores and faults
- rsp_err  out  1  access faulted
- rsp_cause  out  2  00 none, 01 misaligned, 10 illegal funct3

Behaviour:
- Clock/reset: one clock (clk); rst_n is asynchronous and active-low.
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_cause=00. RAM contents are not reset.
- FSM states IDLE, ACCESS, RESP:
  - IDLE: req_ready=1. On req_valid, latch we/funct3/addr/wdata and go to ACCESS.
  - ACCESS: req_ready=0. Decode the latched request.
    - If legal and aligned: drive RAM enable, byte enables and wdata; the RAM read/write commits at the end of this cycle.
    - If faulted: no RAM write occurs.
    - Always go to RESP.
  - RESP: rsp_valid=1 and outputs held stable until rsp_ready=1, then go to IDLE. req_ready=0 in RESP.
- Latency and throughput: handshake at edge T, rsp_valid at cycle T+2; one request per 3 cycles minimum.
- Loads (funct3): 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; with DATA_W=64 also 011 LD and 110 LWU.
  - Lane selected by addr[log2(DATA_W/8)-1:0].
  - Signed loads sign-extend to DATA_W; unsigned loads zero-extend.
- Stores (funct3): 000 SB, 001 SH, 010 SW; with DATA_W=64 also 011 SD.
  - Data is replicated across lanes; byte enables select only the addressed bytes. No read-modify-write; untouched bytes are preserved.
- Word index into the RAM = addr >> log2(DATA_W/8).
- Misaligned: H with addr[0]≠0; W with addr[1:0]≠0; D with addr[2:0]≠0. Result: rsp_err=1, rsp_cause=01, rsp_rdata=0, no write.
- Illegal: any funct3 not listed above for the configured width and direction (e.g. 011 when DATA_W=32, 111 always, 100/101/110 with req_we=1). Result: rsp_err=1, rsp_cause=10, no write. Illegal takes priority over misaligned.
- Reset mid-operation:
  - rst_n low during ACCESS: no write commits at that edge if reset is already asserted.
  - Any reset: FSM returns to IDLE and any pending response is discarded.
- req_valid high while req_ready=0 is ignored; the requester holds it.

Decomposition:
- Package dmem_pkg holds:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_D, F3_BU, F3_HU, F3_WU)
  - state enum (IDLE, ACCESS, RESP)
  - cause enum (CAUSE_NONE, CAUSE_MISALIGN, CAUSE_ILLEGAL)
  - function byte_en(funct3, offset, DATA_W)
- Sub-module dmem_bank: DATA_W/8-lane synchronous single-port RAM.
  - Ports: en, we, be, addr, wdata, rdata.
  - rdata is valid the cycle after en.
  - No reset on contents.

Test Plan:
- DATA_W=32: SW 0xDEADBEEF @0x010, then LW @0x010 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid exactly 2 cycles after handshake.
- SB 0x80 @0x013, then LB @0x013 -> 0xFFFFFF80; LBU @0x013 -> 0x00000080; LW @0x010 -> 0x80ADBEEF (other bytes preserved).
- SH 0x1234 @0x012, LH @0x012 -> 0x00001234; LH @0x011 -> err=1, cause=01, rdata=0; a following LW @0x010 returns 0x1234BEEF (no write on fault).
- DATA_W=32: LD (011) @0x000 -> cause=10. DATA_W=64: SD 0x8000000012345678 @0x008, LWU @0x00C -> 0x0000000080000000, LW @0x00C -> 0xFFFFFFFF80000000.
- Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0 throughout; a new request is accepted only after the rsp handshake.
- Reset mid-op: SW 0xAAAAAAAA @0x020 accepted, rst_n low during ACCESS -> after release req_ready=1, rsp_valid=0; LW @0x020 returns the prior contents.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the load/store unit and its RAM bank.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'b00,
        CAUSE_MISALIGN = 2'b01,
        CAUSE_ILLEGAL  = 2'b10
    } cause_t;

    // Access size comes from funct3[1:0]; the mask is shifted to the addressed lane.
    function automatic logic [7:0] byte_en(input logic [2:0] funct3, input logic [2:0] offset,
                                           input int data_w);
        logic [7:0] m;
        logic [2:0] off;
        off = (data_w == 64) ? offset : {1'b0, offset[1:0]};
        case (funct3[1:0])
            2'd0:    m = 8'h01;
            2'd1:    m = 8'h03;
            2'd2:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m << off;
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// Byte-lane synchronous single-port RAM; read data appears the cycle after en.
module dmem_bank #(
    parameter int DEPTH_W = 7,
    parameter int DATA_W  = 32
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [DEPTH_W-1:0]    addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);
    localparam int NB = DATA_W / 8;

    logic [NB-1:0][7:0] mem [0:(2**DEPTH_W)-1];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < NB; i++)
                    if (be[i]) mem[addr][i] <= wdata[i*8 +: 8];
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_lsu.sv
// MEM-stage load/store unit: one request at a time, sub-word formatting,
// fault detection and a held response over a valid/ready handshake.
module dmem_lsu
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [1:0]        rsp_cause
);
    localparam int NB     = DATA_W / 8;
    localparam int OFF_W  = $clog2(NB);
    localparam int WIDX_W = ADDR_W - OFF_W;

    if (DATA_W != 32 && DATA_W != 64) begin : g_bad_width
        $error("dmem_lsu: DATA_W must be 32 or 64");
    end

    state_t            state, nxt;
    logic              q_we;
    logic [2:0]        q_f3;
    logic [ADDR_W-1:0] q_addr;
    logic [DATA_W-1:0] q_wdata;
    logic              illegal, misalign, fault;
    cause_t            cause;
    logic              bank_en;
    logic [DATA_W-1:0] wrep, bank_rdata, lane, ld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt       = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) nxt = ACCESS;
            end
            ACCESS: nxt = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    // Request is captured once and held through ACCESS and RESP so the response stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_we    <= 1'b0;
            q_f3    <= 3'b000;
            q_addr  <= '0;
            q_wdata <= '0;
        end else if (state == IDLE && req_valid) begin
            q_we    <= req_we;
            q_f3    <= req_funct3;
            q_addr  <= req_addr;
            q_wdata <= req_wdata;
        end
    end

    always_comb begin
        illegal = 1'b0;
        case (q_f3)
            F3_B, F3_H, F3_W: illegal = 1'b0;
            F3_D:             illegal = (DATA_W != 64);
            F3_BU, F3_HU:     illegal = q_we;
            F3_WU:            illegal = q_we || (DATA_W != 64);
            default:          illegal = 1'b1;
        endcase
        misalign = 1'b0;
        case (q_f3[1:0])
            2'd1:    misalign = q_addr[0];
            2'd2:    misalign = |q_addr[1:0];
            2'd3:    misalign = |q_addr[2:0];
            default: misalign = 1'b0;
        endcase
        fault = illegal | misalign;
        cause = illegal ? CAUSE_ILLEGAL : (misalign ? CAUSE_MISALIGN : CAUSE_NONE);
    end

    always_comb begin
        case (q_f3[1:0])
            2'd0:    wrep = {NB{q_wdata[7:0]}};
            2'd1:    wrep = {(NB/2){q_wdata[15:0]}};
            2'd2:    wrep = {(DATA_W/32){q_wdata[31:0]}};
            default: wrep = q_wdata;
        endcase
    end

    // Gating with rst_n keeps a reset asserted during ACCESS from committing a write.
    assign bank_en = (state == ACCESS) && !fault && rst_n;

    dmem_bank #(.DEPTH_W(WIDX_W), .DATA_W(DATA_W)) u_bank (
        .clk   (clk),
        .en    (bank_en),
        .we    (q_we),
        .be    (NB'(byte_en(q_f3, 3'(q_addr[OFF_W-1:0]), DATA_W))),
        .addr  (q_addr[ADDR_W-1:OFF_W]),
        .wdata (wrep),
        .rdata (bank_rdata)
    );

    assign lane = bank_rdata >> {q_addr[OFF_W-1:0], 3'b000};

    always_comb begin
        case (q_f3)
            F3_B:    ld = DATA_W'($signed(lane[7:0]));
            F3_H:    ld = DATA_W'($signed(lane[15:0]));
            F3_W:    ld = DATA_W'($signed(lane[31:0]));
            F3_BU:   ld = DATA_W'(lane[7:0]);
            F3_HU:   ld = DATA_W'(lane[15:0]);
            F3_WU:   ld = DATA_W'(lane[31:0]);
            default: ld = lane;
        endcase
    end

    assign rsp_rdata = (state == RESP && !q_we && !fault) ? ld : '0;
    assign rsp_err   = (state == RESP) && fault;
    assign rsp_cause = (state == RESP) ? cause : CAUSE_NONE;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: a 32-bit and a 64-bit instance sharing clock and reset.
module tb_dmem_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        v32, v64, rdy32, rdy64;
    logic        req_we;
    logic [2:0]  req_f3;
    logic [8:0]  req_addr;
    logic [63:0] req_wdata;
    logic        rsp_ready;
    logic        val32, val64, err32, err64;
    logic [31:0] rd32;
    logic [63:0] rd64;
    logic [1:0]  c32, c64;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dmem_lsu #(.ADDR_W(9), .DATA_W(32)) u32 (
        .clk(clk), .rst_n(rst_n), .req_valid(v32), .req_ready(rdy32), .req_we(req_we),
        .req_funct3(req_f3), .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
        .rsp_valid(val32), .rsp_ready(rsp_ready), .rsp_rdata(rd32), .rsp_err(err32),
        .rsp_cause(c32)
    );

    dmem_lsu #(.ADDR_W(9), .DATA_W(64)) u64 (
        .clk(clk), .rst_n(rst_n), .req_valid(v64), .req_ready(rdy64), .req_we(req_we),
        .req_funct3(req_f3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(val64), .rsp_ready(rsp_ready), .rsp_rdata(rd64), .rsp_err(err64),
        .rsp_cause(c64)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full request/response; checks acceptance, latency and the formatted response.
    task automatic xact(input string tag, input bit w64, input logic we, input logic [2:0] f3,
                        input logic [8:0] a, input logic [63:0] wd, input logic [63:0] exp_rd,
                        input logic exp_err, input logic [1:0] exp_cause);
        int lat;
        @(negedge clk);
        req_we = we; req_f3 = f3; req_addr = a; req_wdata = wd;
        if (w64) v64 = 1'b1; else v32 = 1'b1;
        chk({tag, "/ready"}, w64 ? rdy64 : rdy32, 1);
        @(posedge clk); #1;
        v32 = 1'b0; v64 = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!(w64 ? val64 : val32) && lat < 8);
        chk({tag, "/latency"}, lat, 2);
        chk({tag, "/rdata"}, w64 ? rd64 : {32'h0, rd32}, exp_rd);
        chk({tag, "/err"}, w64 ? err64 : err32, exp_err);
        chk({tag, "/cause"}, w64 ? c64 : c32, exp_cause);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        int lat;
        rst_n = 1'b0; v32 = 1'b0; v64 = 1'b0; req_we = 1'b0; req_f3 = 3'b000;
        req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst/ready32", rdy32, 1);
        chk("rst/valid32", val32, 0);
        chk("rst/rdata32", rd32, 0);
        chk("rst/err32", err32, 0);
        chk("rst/cause32", c32, 0);
        chk("rst/ready64", rdy64, 1);
        chk("rst/valid64", val64, 0);
        rst_n = 1'b1;

        // 32-bit word, byte and halfword paths
        xact("sw",       0, 1, 3'b010, 9'h010, 64'hDEADBEEF, 0, 0, 2'b00);
        xact("lw1",      0, 0, 3'b010, 9'h010, 0, 64'hDEADBEEF, 0, 2'b00);
        xact("sb",       0, 1, 3'b000, 9'h013, 64'h80, 0, 0, 2'b00);
        xact("lb",       0, 0, 3'b000, 9'h013, 0, 64'hFFFFFF80, 0, 2'b00);
        xact("lbu",      0, 0, 3'b100, 9'h013, 0, 64'h00000080, 0, 2'b00);
        xact("lw2",      0, 0, 3'b010, 9'h010, 0, 64'h80ADBEEF, 0, 2'b00);
        xact("sh",       0, 1, 3'b001, 9'h012, 64'h1234, 0, 0, 2'b00);
        xact("lh",       0, 0, 3'b001, 9'h012, 0, 64'h00001234, 0, 2'b00);
        xact("lh_neg",   0, 0, 3'b001, 9'h010, 0, 64'hFFFFBEEF, 0, 2'b00);
        xact("lh_mis",   0, 0, 3'b001, 9'h011, 0, 0, 1, 2'b01);
        xact("sw_mis",   0, 1, 3'b010, 9'h011, 64'hFFFFFFFF, 0, 1, 2'b01);
        xact("lw3",      0, 0, 3'b010, 9'h010, 0, 64'h1234BEEF, 0, 2'b00);
        xact("ld_32",    0, 0, 3'b011, 9'h000, 0, 0, 1, 2'b10);
        xact("st_f3_4",  0, 1, 3'b100, 9'h010, 64'h55, 0, 1, 2'b10);
        xact("ill_prio", 0, 0, 3'b111, 9'h001, 0, 0, 1, 2'b10);
        xact("lw4",      0, 0, 3'b010, 9'h010, 0, 64'h1234BEEF, 0, 2'b00);

        // 64-bit instance: doubleword and word-unsigned paths
        xact("sd",       1, 1, 3'b011, 9'h008, 64'h8000000012345678, 0, 0, 2'b00);
        xact("lwu",      1, 0, 3'b110, 9'h00C, 0, 64'h0000000080000000, 0, 2'b00);
        xact("lw64",     1, 0, 3'b010, 9'h00C, 0, 64'hFFFFFFFF80000000, 0, 2'b00);
        xact("lw64_lo",  1, 0, 3'b010, 9'h008, 0, 64'h0000000012345678, 0, 2'b00);
        xact("lh64",     1, 0, 3'b001, 9'h00A, 0, 64'h0000000000001234, 0, 2'b00);
        xact("lb64",     1, 0, 3'b000, 9'h00F, 0, 64'hFFFFFFFFFFFFFF80, 0, 2'b00);
        xact("sd_mis",   1, 1, 3'b011, 9'h00C, 64'h0, 0, 1, 2'b01);
        xact("sw64",     1, 1, 3'b010, 9'h00C, 64'h11223344, 0, 0, 2'b00);
        xact("ld64",     1, 0, 3'b011, 9'h008, 0, 64'h1122334412345678, 0, 2'b00);

        // Backpressure: response held while a new request waits
        @(negedge clk);
        req_we = 1'b0; req_f3 = 3'b010; req_addr = 9'h010; v32 = 1'b1;
        @(posedge clk); #1;
        v32 = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!val32 && lat < 8);
        chk("bp/latency", lat, 2);
        req_we = 1'b1; req_f3 = 3'b010; req_addr = 9'h030; req_wdata = 64'h5A5A5A5A; v32 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp/valid", val32, 1);
            chk("bp/rdata", rd32, 64'h1234BEEF);
            chk("bp/ready", rdy32, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("bp/ready_after", rdy32, 1);
        chk("bp/valid_after", val32, 0);
        @(posedge clk); #1;
        v32 = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!val32 && lat < 8);
        chk("bp/st_latency", lat, 2);
        chk("bp/st_err", err32, 0);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        xact("bp_lw",    0, 0, 3'b010, 9'h030, 0, 64'h5A5A5A5A, 0, 2'b00);

        // Reset asserted during ACCESS discards the store
        xact("pre_sw",   0, 1, 3'b010, 9'h020, 64'h13579BDF, 0, 0, 2'b00);
        @(negedge clk);
        req_we = 1'b1; req_f3 = 3'b010; req_addr = 9'h020; req_wdata = 64'hAAAAAAAA; v32 = 1'b1;
        @(posedge clk); #1;
        v32 = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst/ready", rdy32, 1);
        chk("mid_rst/valid", val32, 0);
        chk("mid_rst/rdata", rd32, 0);
        chk("mid_rst/err", err32, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst/ready_rel", rdy32, 1);
        chk("mid_rst/valid_rel", val32, 0);
        xact("post_lw",  0, 0, 3'b010, 9'h020, 0, 64'h13579BDF, 0, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
